// File: rtl/touch_i2c_pkg.sv
// Shared types and constants for the touch-controller I2C target.
package touch_i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_ACK_DEV,
        ST_REG_H,
        ST_ACK_H,
        ST_REG_L,
        ST_ACK_L,
        ST_WR_DATA,
        ST_ACK_WR,
        ST_RD_LOAD,
        ST_RD_SHIFT,
        ST_RD_MACK,
        ST_WAIT_STOP
    } i2c_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam logic [6:0]  GT9XX_ADDR_A     = 7'h14;
    localparam logic [6:0]  GT9XX_ADDR_B     = 7'h5D;
    localparam logic [15:0] GT9XX_REG_ID     = 16'h8140;
    localparam logic [15:0] GT9XX_REG_STATUS = 16'h814E;

    // In 8-bit pointer mode the upper byte stays zero and the low byte wraps on its own.
    function automatic logic [15:0] ptr_next(input logic [15:0] ptr, input logic addr_16b);
        ptr_next = addr_16b ? (ptr + 16'd1) : {8'h00, ptr[7:0] + 8'd1};
    endfunction

endpackage

// File: rtl/touch_i2c_if.sv
// I2C line and register-file port bundle between the touch I2C target and its host.
interface touch_i2c_if;
    logic        scl;
    logic        sda_in;
    logic        sda_oe;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_we;
    logic        reg_rd;
    logic [7:0]  reg_rdata;
    logic        busy;

    modport slave (
        input  scl, sda_in, reg_rdata,
        output sda_oe, reg_addr, reg_wdata, reg_we, reg_rd, busy
    );

    modport master (
        output scl, sda_in, reg_rdata,
        input  sda_oe, reg_addr, reg_wdata, reg_we, reg_rd, busy
    );
endinterface

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers with bus edge, START and STOP detection pulses.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda_in,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    // One stage beyond the synchronizer keeps the previous sample for edge detection.
    logic [SYNC_STAGES:0] scl_pipe_q, scl_pipe_d;
    logic [SYNC_STAGES:0] sda_pipe_q, sda_pipe_d;
    logic                 scl_s, scl_p, sda_p;

    always_comb begin
        scl_pipe_d = {scl_pipe_q[SYNC_STAGES-1:0], scl};
        sda_pipe_d = {sda_pipe_q[SYNC_STAGES-1:0], sda_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_pipe_q <= '1;
            sda_pipe_q <= '1;
        end else begin
            scl_pipe_q <= scl_pipe_d;
            sda_pipe_q <= sda_pipe_d;
        end
    end

    assign scl_s     = scl_pipe_q[SYNC_STAGES-1];
    assign scl_p     = scl_pipe_q[SYNC_STAGES];
    assign sda_s     = sda_pipe_q[SYNC_STAGES-1];
    assign sda_p     = sda_pipe_q[SYNC_STAGES];
    assign scl_rise  = scl_s & ~scl_p;
    assign scl_fall  = ~scl_s & scl_p;
    assign start_det = scl_s & scl_p & sda_p & ~sda_s;
    assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;
endmodule

// File: rtl/touch_i2c_slave.sv
// Touch-controller I2C target: device address match, register pointer, byte-wide reg-file access.
//   state     | meaning
//   IDLE      | bus free or not addressed
//   DEV_ADDR  | shifting in device address + R/W
//   ACK_DEV   | acknowledging device address
//   REG_H/L   | shifting in pointer high / low byte
//   ACK_H/L   | acknowledging pointer byte
//   WR_DATA   | shifting in write byte
//   ACK_WR    | acknowledging write byte, then pointer advance
//   RD_LOAD   | fetching read byte from reg file
//   RD_SHIFT  | driving read byte MSB first
//   RD_MACK   | sampling master ACK/NACK
//   WAIT_STOP | read ended by NACK, waiting for STOP/Sr
module touch_i2c_slave
    import touch_i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = GT9XX_ADDR_A,
    parameter bit         ADDR_16B    = 1'b1,
    parameter int         SYNC_STAGES = 2
) (
    input logic        clk,
    input logic        rst_n,
    touch_i2c_if.slave bus
);
    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl       (bus.scl),
        .sda_in    (bus.sda_in),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_e  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        rw_q, rw_d;
    logic [1:0]  rd_cnt_q, rd_cnt_d;
    logic        sda_oe_q, sda_oe_d;
    logic        reg_we_q, reg_we_d;
    logic        reg_rd_q, reg_rd_d;
    logic        busy_q, busy_d;
    logic [15:0] reg_addr_q, reg_addr_d;
    logic [7:0]  reg_wdata_q, reg_wdata_d;
    logic [7:0]  rx_byte;
    logic        last_bit;

    assign rx_byte  = {shreg_q[6:0], sda_s};
    assign last_bit = (bit_cnt_q == 3'd7);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        rw_d        = rw_q;
        rd_cnt_d    = rd_cnt_q;
        sda_oe_d    = sda_oe_q;
        reg_we_d    = 1'b0;
        reg_rd_d    = 1'b0;
        busy_d      = busy_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        if (stop_det) begin
            state_d   = ST_IDLE;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 3'd0;
        end else if (start_det) begin
            state_d   = ST_DEV_ADDR;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
        end else begin
            unique case (state_q)
                ST_DEV_ADDR, ST_REG_H, ST_REG_L, ST_WR_DATA: begin
                    if (scl_rise) begin
                        shreg_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            if (state_q == ST_DEV_ADDR) begin
                                if (rx_byte[7:1] == SLAVE_ADDR && rx_byte[7:1] != 7'd0) begin
                                    state_d = ST_ACK_DEV;
                                    rw_d    = rx_byte[0];
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = ST_IDLE;
                                end
                            end else if (state_q == ST_REG_H) begin
                                reg_addr_d[15:8] = rx_byte;
                                state_d          = ST_ACK_H;
                            end else if (state_q == ST_REG_L) begin
                                reg_addr_d = {ADDR_16B ? reg_addr_q[15:8] : 8'h00, rx_byte};
                                state_d    = ST_ACK_L;
                            end else begin
                                reg_wdata_d = rx_byte;
                                reg_we_d    = 1'b1;
                                state_d     = ST_ACK_WR;
                            end
                        end
                    end
                end
                // First falling edge starts the ACK, the second one ends the ACK slot.
                ST_ACK_DEV, ST_ACK_H, ST_ACK_L, ST_ACK_WR: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                            if (state_q == ST_ACK_DEV && rw_q) begin
                                state_d  = ST_RD_LOAD;
                                reg_rd_d = 1'b1;
                                rd_cnt_d = 2'd2;
                            end
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd0;
                            if (state_q == ST_ACK_DEV) begin
                                state_d = ADDR_16B ? ST_REG_H : ST_REG_L;
                            end else if (state_q == ST_ACK_H) begin
                                state_d = ST_REG_L;
                            end else begin
                                state_d = ST_WR_DATA;
                                if (state_q == ST_ACK_WR) begin
                                    reg_addr_d = ptr_next(reg_addr_q, ADDR_16B);
                                end
                            end
                        end
                    end
                end
                ST_RD_LOAD: begin
                    if (rd_cnt_q != 2'd0) begin
                        rd_cnt_d = rd_cnt_q - 2'd1;
                        if (rd_cnt_q == 2'd1) begin
                            shreg_d = bus.reg_rdata;
                        end
                    end else if (scl_fall) begin
                        sda_oe_d  = ~shreg_q[7];
                        shreg_d   = {shreg_q[6:0], 1'b0};
                        bit_cnt_d = 3'd0;
                        state_d   = ST_RD_SHIFT;
                    end
                end
                ST_RD_SHIFT: begin
                    if (scl_fall) begin
                        if (last_bit) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd0;
                            state_d   = ST_RD_MACK;
                        end else begin
                            sda_oe_d  = ~shreg_q[7];
                            shreg_d   = {shreg_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_RD_MACK: begin
                    if (scl_rise) begin
                        reg_addr_d = ptr_next(reg_addr_q, ADDR_16B);
                        bit_cnt_d  = 3'd0;
                        if (sda_s == I2C_ACK) begin
                            state_d  = ST_RD_LOAD;
                            reg_rd_d = 1'b1;
                            rd_cnt_d = 2'd2;
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shreg_q     <= 8'h00;
            rw_q        <= 1'b0;
            rd_cnt_q    <= 2'd0;
            sda_oe_q    <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            busy_q      <= 1'b0;
            reg_addr_q  <= 16'h0000;
            reg_wdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            rw_q        <= rw_d;
            rd_cnt_q    <= rd_cnt_d;
            sda_oe_q    <= sda_oe_d;
            reg_we_q    <= reg_we_d;
            reg_rd_q    <= reg_rd_d;
            busy_q      <= busy_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
        end
    end

    assign bus.sda_oe    = sda_oe_q;
    assign bus.reg_we    = reg_we_q;
    assign bus.reg_rd    = reg_rd_q;
    assign bus.busy      = busy_q;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
endmodule
